nco_square_pwm_generator: RTL and testbench
===========================================

Name: nco_square_pwm_generator

Overview:
Parametrised successor to the team's digital square-wave VCO. A phase-accumulator NCO with a selectable frequency range, square or PWM output, glitch-free control updates at period boundaries, and a graceful stop. It drives clock-like and PWM test outputs from the single 1 MHz system clock.

Parameters:
ACC_W, 24, phase accumulator width.
CTRL_W, 3, width of control_frequency.
DUTY_W, 8, duty-cycle word width; the comparator uses acc[ACC_W-1 -: DUTY_W].
STEP_LO, 1677722, base increment for range=0 (100 kHz at 1 MHz clk).
STEP_HI, 1678, base increment for range=1 (100 Hz at 1 MHz clk).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  run request.
range  input  1  0 selects STEP_LO, 1 selects STEP_HI.
control_frequency  input  CTRL_W  frequency multiplier minus one.
mode  input  1  0 = 50% square, 1 = PWM using duty.
duty  input  DUTY_W  PWM high fraction, duty/2^DUTY_W.
square_wave  output  1  registered waveform.
period_tick  output  1  one-cycle pulse per completed period.
active  output  1  generator running.

Behaviour:
- Reset is asynchronous (rst_n low). It clears acc, inc_q, duty_q, mode_q, square_wave, period_tick and active to 0 immediately. Reset mid-operation aborts the current period with no completion tick.
- Increment request: inc_req = (control_frequency+1) * (range ? STEP_HI : STEP_LO), computed at ACC_W+CTRL_W bits.
- Clamp: if inc_req >= 2^(ACC_W-1), the increment is clamped to 2^(ACC_W-1), which caps the output at fclk/2.
- Shadow registers inc_q, duty_q and mode_q load from the inputs only at these points:
  - a start edge;
  - a wrap edge.
  Input changes mid-period have no effect until the next wrap.
- Idle (active=0):
  - acc holds 0 and square_wave=0.
  - enable=1 sampled at an edge is a start edge: shadows load, active<=1, acc stays 0, and square_wave <= f(0, new shadows), i.e. high unless PWM with duty=0.
  - enable=0 while idle: nothing changes.
- Running (active=1):
  - Each edge: acc <= (acc + inc_q) mod 2^ACC_W.
  - A wrap edge is a carry out of that sum.
- At a wrap edge:
  - period_tick<=1 for exactly one cycle; otherwise it is 0.
  - Shadows reload from the inputs.
  - If enable=0 at a wrap edge: active<=0, acc<=0, square_wave<=0, and period_tick still pulses for that final period.
  - Deasserting enable mid-period never truncates a period. Re-asserting enable before the wrap continues without interruption.
- Waveform function f, using ph = acc[ACC_W-1 -: DUTY_W]:
  - mode_q=0: square_wave = ~acc[ACC_W-1].
  - mode_q=1: square_wave = (ph < duty_q).
  - Evaluation is registered on the same edge as the acc update. It uses the post-update acc value and the shadows in effect after that edge, so new duty/mode apply from the first cycle of the new period.
- Edge cases:
  - duty=0 gives constant low.
  - duty=2^DUTY_W-1 gives high except the last 1/2^DUTY_W of the period.
  - period_tick pulses continue in both cases.
- Frequency: f_out = inc_q * f_clk / 2^ACC_W. The period length in cycles may vary by ±1 because of accumulator residue (no phase reset at wrap).
- Simultaneous events: a wrap and an input change on the same edge means the edge-sampled inputs are loaded.

Test Plan:
1. Reset, then range=0, cf=000, mode=0, enable=1 (1 MHz clk) -> inc_q=1677722; period_tick every 10 cycles; square_wave high 5 / low 5 cycles (100 kHz) for the first 1000 periods.
2. Change to cf=100 mid-period -> no change until the next period_tick; then inc_req=8388610 is clamped to 8388608, and square_wave toggles every cycle with period 2 cycles (500 kHz) and ticks every 2 cycles.
3. range=1, cf=001 -> inc_q=3356; period_tick spacing of 4999 or 5000 cycles (≈200 Hz); the high phase ends when acc >= 2^23.
4. mode=1, duty=64, range=0, cf=000 -> square_wave high 3 cycles, low 7 per period. Then duty=0 -> constant low from the next period, while period_tick continues every 10 cycles.
5. Running with enable dropped 3 cycles after a tick -> the period completes; on the wrap edge period_tick=1, active=0, square_wave=0, and no further ticks. Re-enabling restarts with acc=0 and square_wave=1.
6. Assert rst_n=0 asynchronously mid-period (between clock edges) -> all outputs read 0 before the next clk edge; after release with enable=1 -> clean restart per scenario 1.

Source files
------------

// File: rtl/nco_square_pwm_generator.sv
// Phase-accumulator NCO producing a square or PWM waveform with control updates
// taken only at period boundaries, and a stop that always finishes the current period.
module nco_square_pwm_generator #(
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned CTRL_W  = 3,
    parameter int unsigned DUTY_W  = 8,
    parameter int unsigned STEP_LO = 1677722,
    parameter int unsigned STEP_HI = 1678
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              range,
    input  logic [CTRL_W-1:0] control_frequency,
    input  logic              mode,
    input  logic [DUTY_W-1:0] duty,
    output logic              square_wave,
    output logic              period_tick,
    output logic              active
);

    localparam int unsigned ReqW = ACC_W + CTRL_W;
    localparam logic [ReqW-1:0] IncMax = ReqW'(1) << (ACC_W - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    inc_q, inc_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic                mode_q, mode_d;
    logic                square_d, tick_d;

    logic [ReqW-1:0]     cf_plus1, step_sel, inc_req;
    logic [ACC_W-1:0]    inc_new;
    logic [ACC_W:0]      sum;
    logic                wrap, load;

    function automatic logic wave(input logic [ACC_W-1:0] a, input logic m,
                                  input logic [DUTY_W-1:0] d);
        return m ? (a[ACC_W-1 -: DUTY_W] < d) : ~a[ACC_W-1];
    endfunction

    // Requested increment, clamped so the output never exceeds fclk/2.
    always_comb begin
        cf_plus1 = ReqW'(control_frequency) + ReqW'(1);
        step_sel = range ? ReqW'(STEP_HI) : ReqW'(STEP_LO);
        inc_req  = cf_plus1 * step_sel;
        inc_new  = (inc_req >= IncMax) ? IncMax[ACC_W-1:0] : inc_req[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            inc_q       <= '0;
            duty_q      <= '0;
            mode_q      <= 1'b0;
            square_wave <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            inc_q       <= inc_d;
            duty_q      <= duty_d;
            mode_q      <= mode_d;
            square_wave <= square_d;
            period_tick <= tick_d;
        end
    end

    always_comb begin
        sum  = {1'b0, acc_q} + {1'b0, inc_q};
        wrap = (state_q == StRun) && sum[ACC_W];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = StRun;
            StRun:   if (wrap && !enable) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Shadows switch on the same edge as the wave, so a new period starts with new settings.
    always_comb begin
        load     = ((state_q == StIdle) && enable) || wrap;
        inc_d    = load ? inc_new : inc_q;
        duty_d   = load ? duty : duty_q;
        mode_d   = load ? mode : mode_q;
        tick_d   = wrap;
        acc_d    = '0;
        square_d = 1'b0;
        if (state_q == StIdle) begin
            if (enable) square_d = wave('0, mode_d, duty_d);
        end else if (!(wrap && !enable)) begin
            acc_d    = sum[ACC_W-1:0];
            square_d = wave(sum[ACC_W-1:0], mode_d, duty_d);
        end
    end

    assign active = (state_q == StRun);

endmodule

// File: tb/tb_nco_square_pwm_generator.sv
// Directed bench for nco_square_pwm_generator: per-cycle scoreboard against a
// behavioural reference plus period-length and high-time checks.
module tb_nco_square_pwm_generator;

    localparam int     ACC_W   = 24;
    localparam int     CTRL_W  = 3;
    localparam int     DUTY_W  = 8;
    localparam longint STEP_LO = 1677722;
    localparam longint STEP_HI = 1678;
    localparam longint MODV    = longint'(1) << ACC_W;
    localparam longint HALF    = MODV / 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              range_sel;
    logic [CTRL_W-1:0] control_frequency;
    logic              mode_sel;
    logic [DUTY_W-1:0] duty;
    logic              square_wave;
    logic              period_tick;
    logic              active;

    nco_square_pwm_generator dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .range             (range_sel),
        .control_frequency (control_frequency),
        .mode              (mode_sel),
        .duty              (duty),
        .square_wave       (square_wave),
        .period_tick       (period_tick),
        .active            (active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic sq;
        logic tick;
        logic act;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    longint m_acc, m_inc;
    int     m_duty;
    bit     m_mode, m_active, m_sq, m_tick;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit ref_wave(input longint a, input bit md, input int d);
        if (md) return (a >> (ACC_W - DUTY_W)) < longint'(d);
        return a < HALF;
    endfunction

    function automatic longint ref_inc(input int cf, input bit r);
        longint v;
        v = longint'(cf + 1) * (r ? STEP_HI : STEP_LO);
        if (v >= HALF) v = HALF;
        return v;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_inc = 0; m_duty = 0; m_mode = 0;
        m_active = 0; m_sq = 0; m_tick = 0;
    endtask

    task automatic model_load();
        m_inc  = ref_inc(int'(control_frequency), range_sel);
        m_duty = int'(duty);
        m_mode = mode_sel;
    endtask

    task automatic model_edge();
        longint s;
        if (!rst_n) begin
            model_reset();
        end else if (!m_active) begin
            m_tick = 0;
            if (enable) begin
                model_load();
                m_active = 1;
                m_acc    = 0;
                m_sq     = ref_wave(0, m_mode, m_duty);
            end else begin
                m_sq = 0;
            end
        end else begin
            s = m_acc + m_inc;
            if (s >= MODV) begin
                m_tick = 1;
                model_load();
                if (!enable) begin
                    m_active = 0;
                    m_acc    = 0;
                    m_sq     = 0;
                end else begin
                    m_acc = s - MODV;
                    m_sq  = ref_wave(m_acc, m_mode, m_duty);
                end
            end else begin
                m_tick = 0;
                m_acc  = s;
                m_sq   = ref_wave(m_acc, m_mode, m_duty);
            end
        end
    endtask

    // One clock: predict from the inputs the DUT will sample, then compare after the edge.
    task automatic step();
        exp_t e;
        model_edge();
        sb_q.push_back('{sq: m_sq, tick: m_tick, act: m_active});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("square_wave", square_wave, e.sq);
        check("period_tick", period_tick, e.tick);
        check("active", active, e.act);
    endtask

    task automatic run_until_tick(input int budget, input string tag,
                                  output int cycles, output int highs);
        bit seen;
        seen   = 0;
        cycles = 0;
        highs  = 0;
        while (!seen && cycles < budget) begin
            step();
            cycles++;
            highs += int'(square_wave);
            if (period_tick === 1'b1) seen = 1;
        end
        check({tag, "_tick_seen"}, seen, 1);
    endtask

    initial begin
        int c, h, nt;
        rst_n = 0; enable = 0; range_sel = 0; control_frequency = '0;
        mode_sel = 0; duty = '0;
        model_reset();
        #12;
        check("reset_square_wave", square_wave, 0);
        check("reset_period_tick", period_tick, 0);
        check("reset_active", active, 0);
        step(); step();
        rst_n = 1;
        repeat (3) step();

        // Scenario 1: 100 kHz square
        enable = 1;
        run_until_tick(20, "s1_first", c, h);
        check("s1_first_len", c, 11);
        for (int i = 0; i < 1000; i++) begin
            run_until_tick(20, "s1", c, h);
            check("s1_period", c, 10);
            check("s1_high", h, 5);
        end

        // Scenario 2: mid-period change, clamped increment
        repeat (4) step();
        control_frequency = 3'b100;
        run_until_tick(20, "s2_old", c, h);
        check("s2_old_len", c, 6);
        for (int i = 0; i < 5; i++) begin
            run_until_tick(4, "s2", c, h);
            check("s2_period", c, 2);
            check("s2_high", h, 1);
        end

        // Scenario 3: low range, ~200 Hz
        range_sel = 1; control_frequency = 3'b001;
        run_until_tick(4, "s3_old", c, h);
        run_until_tick(6000, "s3_settle", c, h);
        for (int i = 0; i < 2; i++) begin
            run_until_tick(6000, "s3", c, h);
            check("s3_period_ok", (c == 4999 || c == 5000), 1);
            check("s3_high_ok", (h >= 2498 && h <= 2501), 1);
        end

        // Scenario 4: PWM duty 64/256, then duty 0
        mode_sel = 1; duty = 8'd64; range_sel = 0; control_frequency = 3'b000;
        run_until_tick(6000, "s4_old", c, h);
        for (int i = 0; i < 3; i++) begin
            run_until_tick(20, "s4", c, h);
            check("s4_period", c, 10);
            check("s4_high", h, 3);
        end
        duty = 8'd0;
        run_until_tick(20, "s4_dz_switch", c, h);
        for (int i = 0; i < 3; i++) begin
            run_until_tick(20, "s4_dz", c, h);
            check("s4_dz_period", c, 10);
            check("s4_dz_high", h, 0);
        end

        // Scenario 5: graceful stop and restart
        mode_sel = 0;
        run_until_tick(20, "s5_switch", c, h);
        repeat (3) step();
        enable = 0;
        run_until_tick(20, "s5_stop", c, h);
        check("s5_stop_len", c, 7);
        check("s5_stop_active", active, 0);
        check("s5_stop_square", square_wave, 0);
        nt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            nt += int'(period_tick);
        end
        check("s5_no_ticks", nt, 0);
        check("s5_idle_active", active, 0);
        enable = 1;
        step();
        check("s5_restart_square", square_wave, 1);
        check("s5_restart_active", active, 1);
        run_until_tick(20, "s5_rerun", c, h);
        check("s5_rerun_period", c, 10);
        check("s5_rerun_high", h, 5);

        // Scenario 6: asynchronous reset between edges
        repeat (4) step();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check("s6_async_square", square_wave, 0);
        check("s6_async_tick", period_tick, 0);
        check("s6_async_active", active, 0);
        repeat (3) step();
        rst_n = 1;
        step();
        check("s6_restart_square", square_wave, 1);
        run_until_tick(20, "s6_first", c, h);
        check("s6_first_period", c, 10);
        for (int i = 0; i < 20; i++) begin
            run_until_tick(20, "s6", c, h);
            check("s6_period", c, 10);
            check("s6_high", h, 5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
